// File: rtl/gate_test_pkg.sv
// Shared types and the gate-bank truth table for the gate self-test sequencer.
package gate_test_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NAND = 2;
    localparam int GATE_XOR  = 3;
    localparam int GATE_NOT  = 4;
    localparam int NUM_GATES = 5;

    function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] e;
        e            = '0;
        e[GATE_AND]  = a & b;
        e[GATE_OR]   = a | b;
        e[GATE_NAND] = ~(a & b);
        e[GATE_XOR]  = a ^ b;
        e[GATE_NOT]  = ~a;
        return e;
    endfunction

endpackage

// File: rtl/gate_selftest_seq_if.sv
// Signal bundle between the self-test sequencer and the gate bank / host.
// GATE_SELFTEST_ERRLOG_EN adds the first-failure log outputs.
interface gate_selftest_seq_if;
    import gate_test_pkg::*;

    logic                 start;
    logic                 AND_In;
    logic                 OR_In;
    logic                 NAND_In;
    logic                 XOR_In;
    logic                 NOT_In;
    logic                 A;
    logic                 B;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_GATES-1:0] fail_mask;
    logic [1:0]           vec_idx;
`ifdef GATE_SELFTEST_ERRLOG_EN
    logic                 first_fail_valid;
    logic [1:0]           first_fail_vec;
`endif

    modport slave (
`ifdef GATE_SELFTEST_ERRLOG_EN
        output first_fail_valid, first_fail_vec,
`endif
        input  start, AND_In, OR_In, NAND_In, XOR_In, NOT_In,
        output A, B, busy, done, pass, fail_mask, vec_idx
    );

    modport master (
`ifdef GATE_SELFTEST_ERRLOG_EN
        input  first_fail_valid, first_fail_vec,
`endif
        output start, AND_In, OR_In, NAND_In, XOR_In, NOT_In,
        input  A, B, busy, done, pass, fail_mask, vec_idx
    );

endinterface

// File: rtl/gate_selftest_seq.sv
// Walks the gate bank through all four A/B vectors and accumulates a sticky per-gate fail mask.
// GATE_SELFTEST_ERRLOG_EN adds first_fail_valid / first_fail_vec capture.
//
// state  | meaning
// IDLE   | A=B=0, waiting for start
// DRIVE  | A/B just loaded from vec_idx
// SETTLE | SETTLE_CYCLES down-count while the bank settles
// CHECK  | compare bank outputs, advance or finish
// DONE   | one-cycle done pulse, pass valid
module gate_selftest_seq
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    gate_selftest_seq_if.slave  bus
);

    localparam logic [7:0] SETTLE_LOAD = 8'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    state_t               state;
    logic [7:0]           settle_cnt;
    logic                 a_q;
    logic                 b_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [NUM_GATES-1:0] fail_q;
    logic [1:0]           vec_q;
    logic [1:0]           vec_next;
    logic [NUM_GATES-1:0] gate_in;
    logic [NUM_GATES-1:0] gate_exp;
    logic [NUM_GATES-1:0] mismatch;
`ifdef GATE_SELFTEST_ERRLOG_EN
    logic                 ff_valid_q;
    logic [1:0]           ff_vec_q;
`endif

    always_comb begin
        gate_in            = '0;
        gate_in[GATE_AND]  = bus.AND_In;
        gate_in[GATE_OR]   = bus.OR_In;
        gate_in[GATE_NAND] = bus.NAND_In;
        gate_in[GATE_XOR]  = bus.XOR_In;
        gate_in[GATE_NOT]  = bus.NOT_In;
        gate_exp           = expected_gates(a_q, b_q);
        vec_next           = vec_q + 2'd1;
        // Case inequality so an X/Z from the bank counts as a failure in simulation.
        for (int i = 0; i < NUM_GATES; i++) begin
            mismatch[i] = (gate_in[i] !== gate_exp[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
            vec_q      <= '0;
`ifdef GATE_SELFTEST_ERRLOG_EN
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    a_q <= 1'b0;
                    b_q <= 1'b0;
                    if (bus.start) begin
                        state  <= DRIVE;
                        vec_q  <= '0;
                        busy_q <= 1'b1;
                        fail_q <= '0;
                        pass_q <= 1'b0;
`ifdef GATE_SELFTEST_ERRLOG_EN
                        ff_valid_q <= 1'b0;
                        ff_vec_q   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    if (SETTLE_CYCLES == 0) begin
                        state <= CHECK;
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) state <= CHECK;
                    else                    settle_cnt <= settle_cnt - 8'd1;
                end
                CHECK: begin
                    fail_q <= fail_q | mismatch;
`ifdef GATE_SELFTEST_ERRLOG_EN
                    if ((|mismatch) && !ff_valid_q) begin
                        ff_valid_q <= 1'b1;
                        ff_vec_q   <= vec_q;
                    end
`endif
                    if (vec_q == 2'd3) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        a_q    <= 1'b0;
                        b_q    <= 1'b0;
                        pass_q <= ((fail_q | mismatch) == '0);
                    end else begin
                        state <= DRIVE;
                        vec_q <= vec_next;
                        a_q   <= vec_next[1];
                        b_q   <= vec_next[0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    vec_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_q;
    assign bus.vec_idx   = vec_q;
`ifdef GATE_SELFTEST_ERRLOG_EN
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_vec   = ff_vec_q;
`endif

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq: two instances (SETTLE_CYCLES=2 and 0) driving a modelled gate bank
// with injectable stuck-at faults; results are compared against a truth-table reference.
module tb_gate_selftest_seq;
    import gate_test_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [4:0] s0_f = '0;
    logic [4:0] s1_f = '0;

    gate_selftest_seq_if if0();
    gate_selftest_seq_if if1();

    function automatic logic [4:0] bank_model(input logic a, input logic b,
                                              input logic [4:0] s0, input logic [4:0] s1);
        logic [4:0] t;
        t            = '0;
        t[GATE_AND]  = a & b;
        t[GATE_OR]   = a | b;
        t[GATE_NAND] = ~(a & b);
        t[GATE_XOR]  = a ^ b;
        t[GATE_NOT]  = ~a;
        return (t & ~s0) | s1;
    endfunction

    logic [4:0] bank0, bank1;
    assign bank0 = bank_model(if0.A, if0.B, s0_f, s1_f);
    assign bank1 = bank_model(if1.A, if1.B, s0_f, s1_f);
    assign if0.AND_In = bank0[GATE_AND];
    assign if0.OR_In = bank0[GATE_OR];
    assign if0.NAND_In = bank0[GATE_NAND];
    assign if0.XOR_In = bank0[GATE_XOR];
    assign if0.NOT_In = bank0[GATE_NOT];
    assign if1.AND_In = bank1[GATE_AND];
    assign if1.OR_In = bank1[GATE_OR];
    assign if1.NAND_In = bank1[GATE_NAND];
    assign if1.XOR_In = bank1[GATE_XOR];
    assign if1.NOT_In = bank1[GATE_NOT];

    gate_selftest_seq #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    gate_selftest_seq #(.SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int lat [2] = '{16, 8};

    int         o_done_cyc [2];
    int         o_done_cnt [2];
    int         o_busy     [2];
    int         o_ab_bad   [2];
    int         o_seq_n    [2];
    logic [7:0] o_seq      [2];
    logic [1:0] last_v     [2];
    logic [4:0] o_mask     [2];
    logic       o_pass     [2];

    function automatic logic [4:0] model_mask(input logic [4:0] s0, input logic [4:0] s1);
        logic [4:0] m;
        logic [1:0] vv;
        m = '0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            m  = m | (bank_model(vv[1], vv[0], s0, s1) ^ expected_gates(vv[1], vv[0]));
        end
        return m;
    endfunction

    function automatic logic [2:0] model_first(input logic [4:0] s0, input logic [4:0] s1);
        logic [1:0] vv;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if ((bank_model(vv[1], vv[0], s0, s1) ^ expected_gates(vv[1], vv[0])) != 5'd0)
                return {1'b1, vv};
        end
        return 3'b000;
    endfunction

    task automatic observe(input int d, input int c, input logic busy_s, input logic done_s,
                           input logic a_s, input logic b_s, input logic [1:0] v_s);
        if (done_s === 1'b1) begin
            if (o_done_cnt[d] == 0) o_done_cyc[d] = c;
            o_done_cnt[d]++;
        end
        if (busy_s === 1'b1) begin
            o_busy[d]++;
            if (a_s !== v_s[1] || b_s !== v_s[0]) o_ab_bad[d]++;
            if (o_seq_n[d] == 0 || v_s != last_v[d]) begin
                o_seq[d] = {o_seq[d][5:0], v_s};
                o_seq_n[d]++;
                last_v[d] = v_s;
            end
        end else if (a_s !== 1'b0 || b_s !== 1'b0) begin
            o_ab_bad[d]++;
        end
    endtask

    // Pulses start on both instances; c=0 is the cycle right after the sampling edge.
    task automatic run_pair(input int budget, input int repulse_at);
        for (int d = 0; d < 2; d++) begin
            o_done_cyc[d] = -1; o_done_cnt[d] = 0; o_busy[d] = 0; o_ab_bad[d] = 0;
            o_seq_n[d] = 0; o_seq[d] = '0; last_v[d] = '0;
        end
        @(negedge clk);
        if0.start = 1'b1; if1.start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < budget; c++) begin
            observe(0, c, if0.busy, if0.done, if0.A, if0.B, if0.vec_idx);
            observe(1, c, if1.busy, if1.done, if1.A, if1.B, if1.vec_idx);
            if0.start = (c == repulse_at); if1.start = (c == repulse_at);
            @(negedge clk);
        end
        if0.start = 1'b0; if1.start = 1'b0;
        o_mask[0] = if0.fail_mask; o_mask[1] = if1.fail_mask;
        o_pass[0] = if0.pass;      o_pass[1] = if1.pass;
    endtask

    task automatic test_reset;
        rst = 1'b1; if0.start = 1'b0; if1.start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({if0.A, if0.B, if0.busy, if0.done, if0.pass, if0.vec_idx, if0.fail_mask} !== 12'd0) begin
            bad++; $display("FAIL reset_dut0 got=%b want=0",
                {if0.A, if0.B, if0.busy, if0.done, if0.pass, if0.vec_idx, if0.fail_mask});
        end
        total++;
        if ({if1.A, if1.B, if1.busy, if1.done, if1.pass, if1.vec_idx, if1.fail_mask} !== 12'd0) begin
            bad++; $display("FAIL reset_dut1 got=%b want=0",
                {if1.A, if1.B, if1.busy, if1.done, if1.pass, if1.vec_idx, if1.fail_mask});
        end
`ifdef GATE_SELFTEST_ERRLOG_EN
        total++;
        if ({if0.first_fail_valid, if0.first_fail_vec} !== 3'd0) begin
            bad++; $display("FAIL reset_errlog got=%b want=000", {if0.first_fail_valid, if0.first_fail_vec});
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_healthy;
        s0_f = '0; s1_f = '0;
        run_pair(24, -1);
        for (int d = 0; d < 2; d++) begin
            total++; if (o_done_cyc[d] !== lat[d]) begin bad++; $display("FAIL healthy_latency d%0d got=%0d want=%0d", d, o_done_cyc[d], lat[d]); end
            total++; if (o_done_cnt[d] !== 1) begin bad++; $display("FAIL healthy_done_count d%0d got=%0d want=1", d, o_done_cnt[d]); end
            total++; if (o_busy[d] !== lat[d]) begin bad++; $display("FAIL healthy_busy_len d%0d got=%0d want=%0d", d, o_busy[d], lat[d]); end
            total++; if (o_ab_bad[d] !== 0) begin bad++; $display("FAIL healthy_ab_drive d%0d got=%0d want=0", d, o_ab_bad[d]); end
            total++; if (o_seq_n[d] !== 4 || o_seq[d] !== 8'b00_01_10_11) begin bad++; $display("FAIL healthy_vec_seq d%0d got=%0d/%b want=4/00011011", d, o_seq_n[d], o_seq[d]); end
            total++; if (o_mask[d] !== 5'b00000 || o_pass[d] !== 1'b1) begin bad++; $display("FAIL healthy_result d%0d got=%b/%b want=00000/1", d, o_mask[d], o_pass[d]); end
        end
    endtask

    task automatic test_xor_fault;
        s0_f = 5'b00001 << GATE_XOR; s1_f = '0;
        run_pair(24, -1);
        for (int d = 0; d < 2; d++) begin
            total++; if (o_mask[d] !== 5'b01000 || o_pass[d] !== 1'b0) begin bad++; $display("FAIL xor_fault_result d%0d got=%b/%b want=01000/0", d, o_mask[d], o_pass[d]); end
            total++; if (o_done_cyc[d] !== lat[d]) begin bad++; $display("FAIL xor_fault_latency d%0d got=%0d want=%0d", d, o_done_cyc[d], lat[d]); end
        end
    endtask

    task automatic test_not_stuck;
        s0_f = '0; s1_f = 5'b00001 << GATE_NOT;
        run_pair(24, -1);
        total++; if (o_mask[0] !== 5'b10000 || o_pass[0] !== 1'b0) begin bad++; $display("FAIL not_stuck_result got=%b/%b want=10000/0", o_mask[0], o_pass[0]); end
`ifdef GATE_SELFTEST_ERRLOG_EN
        total++; if (if0.first_fail_valid !== 1'b1 || if0.first_fail_vec !== 2'd2) begin bad++; $display("FAIL not_stuck_errlog got=%b/%0d want=1/2", if0.first_fail_valid, if0.first_fail_vec); end
`endif
    endtask

    task automatic test_start_ignored;
        s0_f = '0; s1_f = '0;
        run_pair(40, 5);
        for (int d = 0; d < 2; d++) begin
            total++; if (o_done_cnt[d] !== 1 || o_done_cyc[d] !== lat[d]) begin bad++; $display("FAIL restart_ignored d%0d got=%0d@%0d want=1@%0d", d, o_done_cnt[d], o_done_cyc[d], lat[d]); end
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        int dn;
        s0_f = '0; s1_f = 5'b00001 << GATE_AND;
        @(negedge clk); if0.start = 1'b1; if1.start = 1'b1;
        @(negedge clk); if0.start = 1'b0; if1.start = 1'b0;
        n = 0;
        while (if0.vec_idx !== 2'd2 && n < 20) begin @(negedge clk); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL midrun_reach_v2 got=timeout want=vec_idx 2"); end
        total++; if (if0.fail_mask === 5'b00000) begin bad++; $display("FAIL midrun_premask got=%b want=nonzero", if0.fail_mask); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({if0.A, if0.B, if0.busy, if0.done, if0.vec_idx, if0.fail_mask} !== 11'd0) begin
            bad++; $display("FAIL midrun_reset_dut0 got=%b want=0", {if0.A, if0.B, if0.busy, if0.done, if0.vec_idx, if0.fail_mask});
        end
        total++;
        if ({if1.A, if1.B, if1.busy, if1.done, if1.vec_idx, if1.fail_mask} !== 11'd0) begin
            bad++; $display("FAIL midrun_reset_dut1 got=%b want=0", {if1.A, if1.B, if1.busy, if1.done, if1.vec_idx, if1.fail_mask});
        end
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (if0.done === 1'b1 || if1.done === 1'b1 || if0.busy === 1'b1) dn++;
            @(negedge clk);
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d want=0", dn); end
        s1_f = '0;
        run_pair(24, -1);
        for (int d = 0; d < 2; d++) begin
            total++; if (o_done_cyc[d] !== lat[d] || o_pass[d] !== 1'b1 || o_mask[d] !== 5'd0) begin bad++; $display("FAIL midrun_fresh d%0d got=%0d/%b/%b want=%0d/1/00000", d, o_done_cyc[d], o_pass[d], o_mask[d], lat[d]); end
        end
    endtask

    task automatic test_back_to_back;
        int first [2];
        int second [2];
        int cnt [2];
        int exp_cnt;
        s0_f = '0; s1_f = '0;
        for (int d = 0; d < 2; d++) begin first[d] = -1; second[d] = -1; cnt[d] = 0; end
        @(negedge clk); if0.start = 1'b1; if1.start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 60; c++) begin
            if (if0.done === 1'b1) begin if (cnt[0] == 0) first[0] = c; else if (cnt[0] == 1) second[0] = c; cnt[0]++; end
            if (if1.done === 1'b1) begin if (cnt[1] == 0) first[1] = c; else if (cnt[1] == 1) second[1] = c; cnt[1]++; end
            @(negedge clk);
        end
        if0.start = 1'b0; if1.start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_cnt = 0;
            for (int c = lat[d]; c < 60; c += lat[d] + 2) exp_cnt++;
            total++; if (first[d] !== lat[d] || second[d] !== 2 * lat[d] + 2) begin bad++; $display("FAIL b2b_timing d%0d got=%0d,%0d want=%0d,%0d", d, first[d], second[d], lat[d], 2 * lat[d] + 2); end
            total++; if (cnt[d] !== exp_cnt) begin bad++; $display("FAIL b2b_count d%0d got=%0d want=%0d", d, cnt[d], exp_cnt); end
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_random;
        logic [4:0] em;
        logic [2:0] ef;
        for (int it = 0; it < 10; it++) begin
            s0_f = 5'($urandom_range(0, 31));
            s1_f = 5'($urandom_range(0, 31)) & ~s0_f;
            em = model_mask(s0_f, s1_f);
            ef = model_first(s0_f, s1_f);
            run_pair(24, -1);
            for (int d = 0; d < 2; d++) begin
                total++; if (o_mask[d] !== em || o_pass[d] !== (em == 5'd0)) begin bad++; $display("FAIL random_result it%0d d%0d s0=%b s1=%b got=%b/%b want=%b/%b", it, d, s0_f, s1_f, o_mask[d], o_pass[d], em, (em == 5'd0)); end
                total++; if (o_done_cyc[d] !== lat[d]) begin bad++; $display("FAIL random_latency it%0d d%0d got=%0d want=%0d", it, d, o_done_cyc[d], lat[d]); end
            end
`ifdef GATE_SELFTEST_ERRLOG_EN
            total++; if ({if0.first_fail_valid, if0.first_fail_vec} !== ef) begin bad++; $display("FAIL random_errlog it%0d got=%b want=%b", it, {if0.first_fail_valid, if0.first_fail_vec}, ef); end
`else
            if (ef[2] === 1'bx) $display("note: unexpected model state");
`endif
        end
    endtask

    initial begin
        if0.start = 1'b0; if1.start = 1'b0;
        test_reset;
        test_healthy;
        test_xor_fault;
        test_not_stuck;
        test_start_ignored;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
